// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core (R, I-arith, LW, SW, BEQ-class).
// Optional perf counters enabled by defining MC_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_sel_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_sel_o,
    output logic             reg_write_o,
    output logic             wb_sel_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       imm_sel_o,
    output logic             halt_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ADDR,
        S_MEM, S_WB, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [1:0] C_R  = 2'd0;
    localparam logic [1:0] C_I  = 2'd1;
    localparam logic [1:0] C_LD = 2'd2;
    localparam logic [1:0] C_ST = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cls;
    logic [1:0] w_cls;
    logic [1:0] r_cause;
    logic [1:0] w_cause;
    logic [7:0] r_wait;
    logic       w_mem_wait;
    logic       w_timeout;
    logic       w_is_st;
    logic       w_is_ld;

    assign w_is_st    = (r_cls == C_ST);
    assign w_is_ld    = (r_cls == C_LD);
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM))
                        && !mem_ready_i;
    // Ready arriving on the last tolerated cycle beats the timeout
    assign w_timeout  = w_mem_wait && (r_wait == WAIT_LAST);

    always_comb begin
        w_cls = C_R;
        unique case (opcode_i)
            OP_I:    w_cls = C_I;
            OP_LD:   w_cls = C_LD;
            OP_ST:   w_cls = C_ST;
            default: w_cls = C_R;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_FETCH;
            r_cls   <= C_R;
            r_cause <= 2'b00;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == S_DECODE)
                r_cls <= w_cls;
            if (w_next != r_state)
                r_wait <= 8'd0;
            else if (w_mem_wait)
                r_wait <= r_wait + 8'd1;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready_i) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_DECODE: begin
                unique case (opcode_i)
                    OP_R, OP_I:   w_next = S_EXEC;
                    OP_LD, OP_ST: w_next = S_ADDR;
                    OP_B:         w_next = S_BRANCH;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = 2'b01;
                    end
                endcase
            end
            S_EXEC:   w_next = S_WB;
            S_ADDR:   w_next = S_MEM;
            S_MEM: begin
                if (mem_ready_i) begin
                    w_next = w_is_st ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
        endcase
    end

    // Outputs are forced low while reset is asserted, even mid-access
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_sel_o   = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_sel_o    = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 1'b0;
        alu_src_o   = 1'b0;
        alu_op_o    = 2'b00;
        imm_sel_o   = 2'b00;
        halt_o      = 1'b0;
        if (rst_i) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req_o  = 1'b1;
                    ir_write_o = mem_ready_i;
                end
                S_DECODE: begin
                end
                S_EXEC: begin
                    alu_op_o  = 2'b10;
                    alu_src_o = (r_cls == C_I);
                end
                S_ADDR: begin
                    alu_src_o = 1'b1;
                    imm_sel_o = w_is_st ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    mem_sel_o  = 1'b1;
                    mem_we_o   = w_is_st;
                    alu_src_o  = 1'b1;
                    imm_sel_o  = w_is_st ? 2'b01 : 2'b00;
                    pc_write_o = w_is_st && mem_ready_i;
                end
                S_WB: begin
                    reg_write_o = 1'b1;
                    wb_sel_o    = w_is_ld;
                    pc_write_o  = 1'b1;
                end
                S_BRANCH: begin
                    alu_op_o   = 2'b01;
                    imm_sel_o  = 2'b10;
                    pc_write_o = 1'b1;
                    pc_sel_o   = zero_i;
                end
                S_TRAP: halt_o = 1'b1;
            endcase
        end
    end

    assign trap_cause_o = r_cause;

`ifdef MC_PERF_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    assign w_retire = (r_state == S_WB) || (r_state == S_BRANCH)
                      || ((r_state == S_MEM) && w_is_st && mem_ready_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_retire)
                r_instr_cnt <= r_instr_cnt + 1'b1;
            if (r_state != S_TRAP)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign instr_cnt_o = r_instr_cnt;
    assign cycle_cnt_o = r_cycle_cnt;
`else
    assign instr_cnt_o = '0;
    assign cycle_cnt_o = '0;
`endif

endmodule
